// File: rtl/demux_reg_1x4.sv
// ============================================================================
// Module  : demux_reg_1x4
// Brief   : Registered 1-to-4 demultiplexer with a wrap-around write pointer,
//           per-slot valid flags, a full flag and a fill-complete pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_reg_1x4 #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic             auto,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       valid,
  output logic [1:0]       ptr,
  output logic             full,
  output logic             done
);

  localparam logic [3:0] c_all_valid = 4'b1111;

  logic [1:0] w_dest;
  logic [3:0] w_valid_nxt;

  assign w_dest      = auto ? ptr : sel;
  assign w_valid_nxt = valid | (4'b0001 << w_dest);
  assign full        = &valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out0  <= '0;
      out1  <= '0;
      out2  <= '0;
      out3  <= '0;
      valid <= '0;
      ptr   <= '0;
      done  <= 1'b0;
    end else if (clear) begin
      out0  <= '0;
      out1  <= '0;
      out2  <= '0;
      out3  <= '0;
      valid <= '0;
      ptr   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        case (w_dest)
          2'd0:    out0 <= in;
          2'd1:    out1 <= in;
          2'd2:    out2 <= in;
          default: out3 <= in;
        endcase
        valid <= w_valid_nxt;
        if (auto) begin
          ptr <= ptr + 2'd1;
        end
        // Pulse only on the load that completes the set, not on overwrites.
        done <= (valid != c_all_valid) && (w_valid_nxt == c_all_valid);
      end
    end
  end

endmodule

`default_nettype wire
